lcd12864_rd_ctrl: RTL and testbench
===================================

Name: lcd12864_rd_ctrl

Overview:
- Read-side bus controller for the LCD12864 (ST7920-class) 8-bit parallel interface. The existing display path only writes; this block performs read cycles with RW=1.
- Two read types:
  - Status read (RS=0): returns the busy flag BF and the address counter AC.
  - Data read (RS=1): returns a RAM byte.
- Optional busy-flag polling before a data read.
- Sits between on-chip control logic (request/ack handshake) and the LCD pins. An external mux shares the pins with the write path.

Parameters:
- T_AS, 4: clk cycles of RS/RW setup before EN rises (80 ns at 50 MHz).
- T_EH, 25: clk cycles EN held high (500 ns). Data is sampled on the last cycle.
- T_H, 2: clk cycles RS/RW held after EN falls.
- T_EL, 25: clk cycles of EN-low recovery before the next access or DONE.
- POLL_MAX, 1023: maximum status polls before timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read request; sampled only in IDLE
- rd_rs  in  1  0 = status read, 1 = data read; captured on accept
- rd_wait  in  1  1 = poll BF until clear before a data read; captured on accept
- rd_busy  out  1  high from the accept cycle through DONE
- rd_ack  out  1  one-cycle pulse; result is valid in the same cycle
- rd_data  out  8  last sampled byte
- rd_bf  out  1  rd_data[7] of the last status read
- rd_ac  out  7  rd_data[6:0] of the last status read
- rd_timeout  out  1  valid with rd_ack; 1 = poll limit hit
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW
- lcd_en  out  1  LCD E
- lcd_dat_i  in  8  LCD data bus input
- lcd_dat_oe  out  1  bus drive enable; constant 0, this block never drives

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Mid-operation reset: lcd_en falls immediately (asynchronously); no rd_ack is produced.
- States: IDLE, SETUP, EN_HI, HOLD, RECOV, DONE. Every state except DONE is counter-timed.
- IDLE:
  - lcd_en=0, lcd_rw=0, lcd_rs=0.
  - When rd_req=1: capture rd_rs and rd_wait, set rd_busy=1, go to SETUP.
  - Phase rule: POLL phase (RS=0) if rd_rs=1 and rd_wait=1, otherwise MAIN phase (RS=rd_rs).
- SETUP: lcd_rw=1, lcd_rs=phase RS, lcd_en=0 for T_AS cycles.
- EN_HI:
  - lcd_en=1 for T_EH cycles.
  - On the final cycle, register lcd_dat_i into rd_data.
  - If phase RS=0, also update rd_bf and rd_ac.
- HOLD: lcd_en=0, RS/RW unchanged, for T_H cycles.
- RECOV: lcd_rw=0, lcd_rs=0, lcd_en=0 for T_EL cycles. Then:
  - POLL phase with BF=1: increment the poll counter, go to SETUP (POLL again).
  - POLL phase with BF=0: go to SETUP in MAIN phase (RS=1).
  - MAIN phase: go to DONE.
- DONE: rd_ack=1 for one cycle, rd_busy drops the next cycle, return to IDLE. rd_req seen in DONE is ignored.
- Timing:
  - Single-access latency (rd_req sampled to rd_ack) = T_AS+T_EH+T_H+T_EL+1 = 57 cycles at defaults.
  - Each extra access (poll) adds 56 cycles.
- Request handling:
  - rd_req outside IDLE is ignored; there is no queueing.
  - rd_req held high through DONE starts a new access in the cycle after DONE.
- A status read with rd_wait=1 does not poll; it returns the first status byte.
- rd_bf and rd_ac hold their values across data reads.
- Poll counter: 10 bits, cleared on accept, saturates at POLL_MAX.

Optional Feature:
- Macro: LCD_RD_TIMEOUT_EN.
- Defined:
  - If the poll counter reaches POLL_MAX with BF still 1, skip the MAIN phase and go to DONE.
  - rd_ack=1 with rd_timeout=1; rd_data holds the last status byte.
- Undefined:
  - Polling continues indefinitely.
  - rd_timeout is tied to 0; the port is still present.

Test Plan:
- Reset: assert rst_n=0 mid-EN_HI -> lcd_en=0 within the same cycle, all outputs 0, no rd_ack after release.
- Status read: rd_req=1, rd_rs=0, lcd_dat_i=8'h05 -> rd_ack at cycle 57, rd_data=8'h05, rd_bf=0, rd_ac=7'h05, lcd_en high exactly 25 cycles, lcd_rw=1 from SETUP through HOLD.
- Data read: rd_rs=1, rd_wait=0, lcd_dat_i=8'h41 -> rd_ack at cycle 57, rd_data=8'h41, lcd_rs=1 during the access, rd_bf/rd_ac unchanged.
- Polled read: rd_rs=1, rd_wait=1; status returns 8'h80 for 3 polls then 8'h12; data=8'h5A -> 4 RS=0 accesses, then 1 RS=1 access, rd_ack at cycle 57+4*56=281, rd_data=8'h5A, rd_ac=7'h12.
- Back-to-back: rd_req held high for 2 requests -> second SETUP starts the cycle after DONE, rd_busy low for exactly 1 cycle, rd_req in DONE ignored.
- Timeout (LCD_RD_TIMEOUT_EN, POLL_MAX=3): BF stuck at 1 -> rd_ack with rd_timeout=1, rd_data=8'h80, no RS=1 access. Without the macro -> still polling after 10 polls, no rd_ack.

Source files
------------

// File: rtl/lcd12864_rd_ctrl.sv
// Read-side bus controller for an ST7920-class LCD: status reads, data reads and optional BF polling.
// Optional poll timeout is enabled with `define LCD_RD_TIMEOUT_EN; otherwise rd_timeout is tied low.
module lcd12864_rd_ctrl #(
  parameter int T_AS     = 4,
  parameter int T_EH     = 25,
  parameter int T_H      = 2,
  parameter int T_EL     = 25,
  parameter int POLL_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_wait,
  output logic       rd_busy,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       rd_bf,
  output logic [6:0] rd_ac,
  output logic       rd_timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_dat_i,
  output logic       lcd_dat_oe
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, RECOV, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        last;
  logic        rs_q;
  logic        poll_q;
  logic [9:0]  poll_cnt;
  logic [9:0]  poll_inc;
  logic        to_hit;
  logic        accept;
  logic        recov_end;
  logic        to_timeout;
  logic        phase_rs;

  assign accept     = (state == IDLE) && rd_req;
  assign recov_end  = (state == RECOV) && last;
  assign phase_rs   = poll_q ? 1'b0 : rs_q;
  assign poll_inc   = (poll_cnt == 10'(POLL_MAX)) ? poll_cnt : poll_cnt + 10'd1;

`ifdef LCD_RD_TIMEOUT_EN
  assign to_hit = (poll_inc == 10'(POLL_MAX));
`else
  assign to_hit = 1'b0;
`endif

  assign to_timeout = recov_end && poll_q && rd_bf && to_hit;

  always_comb begin
    last = 1'b0;
    case (state)
      SETUP:   last = (cnt == 8'(T_AS - 1));
      EN_HI:   last = (cnt == 8'(T_EH - 1));
      HOLD:    last = (cnt == 8'(T_H - 1));
      RECOV:   last = (cnt == 8'(T_EL - 1));
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    lcd_rw     = 1'b0;
    lcd_rs     = 1'b0;
    lcd_en     = 1'b0;
    rd_busy    = 1'b1;
    rd_ack     = 1'b0;
    lcd_dat_oe = 1'b0;
    case (state)
      IDLE: begin
        rd_busy = 1'b0;
        if (rd_req) state_nx = SETUP;
      end
      SETUP: begin
        lcd_rw = 1'b1;
        lcd_rs = phase_rs;
        if (last) state_nx = EN_HI;
      end
      EN_HI: begin
        lcd_rw = 1'b1;
        lcd_rs = phase_rs;
        lcd_en = 1'b1;
        if (last) state_nx = HOLD;
      end
      HOLD: begin
        lcd_rw = 1'b1;
        lcd_rs = phase_rs;
        if (last) state_nx = RECOV;
      end
      RECOV: begin
        // rd_bf already holds the status byte sampled during this access
        if (last) begin
          if (!poll_q)         state_nx = DONE;
          else if (to_timeout) state_nx = DONE;
          else                 state_nx = SETUP;
        end
      end
      DONE: begin
        rd_ack   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      if (last || state == IDLE || state == DONE) cnt <= 8'd0;
      else                                         cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      poll_cnt <= 10'd0;
    end else if (accept) begin
      rs_q     <= rd_rs;
      poll_q   <= rd_rs & rd_wait;
      poll_cnt <= 10'd0;
    end else if (recov_end && poll_q) begin
      if (rd_bf) poll_cnt <= poll_inc;
      else       poll_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'd0;
      rd_bf   <= 1'b0;
      rd_ac   <= 7'd0;
    end else if (state == EN_HI && last) begin
      rd_data <= lcd_dat_i;
      if (!phase_rs) begin
        rd_bf <= lcd_dat_i[7];
        rd_ac <= lcd_dat_i[6:0];
      end
    end
  end

`ifdef LCD_RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rd_timeout <= 1'b0;
    else if (accept)     rd_timeout <= 1'b0;
    else if (to_timeout) rd_timeout <= 1'b1;
  end
`else
  assign rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd12864_rd_ctrl.sv
// Self-checking bench for lcd12864_rd_ctrl: directed cases plus randomized reads against a
// transaction-level model (latency, access counts and returned bytes computed from the read rules).
module tb_lcd12864_rd_ctrl;

`ifdef LCD_RD_TIMEOUT_EN
  localparam int PM = 3;
`else
  localparam int PM = 1023;
`endif
  localparam int ACC = 56;   // cycles per bus access
  localparam int LAT = 57;   // single access, request to ack

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0, rd_rs = 1'b0, rd_wait = 1'b0;
  logic       rd_busy, rd_ack, rd_bf, rd_timeout;
  logic [7:0] rd_data;
  logic [6:0] rd_ac;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_dat_oe;
  logic [7:0] lcd_dat_i = 8'h00;

  lcd12864_rd_ctrl #(.POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_rs(rd_rs), .rd_wait(rd_wait),
    .rd_busy(rd_busy), .rd_ack(rd_ack), .rd_data(rd_data), .rd_bf(rd_bf), .rd_ac(rd_ac),
    .rd_timeout(rd_timeout), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_dat_i(lcd_dat_i), .lcd_dat_oe(lcd_dat_oe)
  );

  always #10 clk = ~clk;

  // LCD model: each EN pulse presents the next status byte (RS=0) or the data byte (RS=1)
  logic [7:0] stat_q[$];
  logic [7:0] stat_dflt = 8'h00;
  logic [7:0] data_byte = 8'h00;
  int         n_rs0 = 0, n_rs1 = 0;
  always @(posedge lcd_en) begin
    if (!lcd_rs) begin
      n_rs0++;
      lcd_dat_i = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
    end else begin
      n_rs1++;
      lcd_dat_i = data_byte;
    end
  end

  int checks = 0, errors = 0;
  logic       exp_bf = 1'b0;
  logic [6:0] exp_ac = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and measure it until rd_ack or the cycle budget runs out.
  int lat, en_cyc, rw_cyc, rs_en_cyc;
  task automatic issue(input logic rs, input logic wt, input int budget);
    bit got;
    n_rs0 = 0; n_rs1 = 0; en_cyc = 0; rw_cyc = 0; rs_en_cyc = 0;
    @(negedge clk);
    rd_rs = rs; rd_wait = wt; rd_req = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      rd_req = 1'b0;
      if (lcd_en) en_cyc++;
      if (lcd_rw) rw_cyc++;
      if (lcd_en && lcd_rs) rs_en_cyc++;
      if (rd_ack) got = 1;
    end
  endtask

  // Model: a read is a list of status accesses followed by an optional data access.
  task automatic run_read(input string tag, input logic rs, input logic wt,
                          input logic [7:0] stats[$], input logic [7:0] dbyte);
    int n_stat, n_main;
    logic [7:0] exp_d, last_st;
    stat_q = stats; data_byte = dbyte;
    n_stat = 0; last_st = 8'h00;
    if (!rs) n_stat = 1;
    else if (wt) begin
      foreach (stats[i]) begin
        n_stat++;
        if (!stats[i][7]) break;
      end
    end
    if (n_stat > 0) last_st = stats[n_stat-1];
    n_main = rs ? 1 : 0;
    exp_d = rs ? dbyte : last_st;
    if (n_stat > 0) begin exp_bf = last_st[7]; exp_ac = last_st[6:0]; end
    issue(rs, wt, 3000);
    chk({tag, "_lat"},   lat, LAT + ACC * (n_stat + n_main - 1));
    chk({tag, "_data"},  rd_data, exp_d);
    chk({tag, "_bf"},    rd_bf, exp_bf);
    chk({tag, "_ac"},    rd_ac, exp_ac);
    chk({tag, "_to"},    rd_timeout, 1'b0);
    chk({tag, "_rs0"},   n_rs0, (rs && !wt) ? 0 : n_stat);
    chk({tag, "_rs1"},   n_rs1, n_main);
    chk({tag, "_en"},    en_cyc, 25 * (n_stat + n_main));
    chk({tag, "_rw"},    rw_cyc, 31 * (n_stat + n_main));
    chk({tag, "_rsen"},  rs_en_cyc, 25 * n_main);
    chk({tag, "_bsy"},   rd_busy, 1'b1);
    @(negedge clk);
    chk({tag, "_idle"},  {rd_busy, rd_ack}, 2'b00);
  endtask

  initial begin
    logic [7:0] sq[$];
    int acks, bsy_low, rw_at, ack2;

    // reset state
    #35;
    chk("rst_out", {rd_busy, rd_ack, rd_data, rd_bf, rd_ac, rd_timeout, lcd_rs, lcd_rw, lcd_en, lcd_dat_oe}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out", {rd_busy, rd_ack, lcd_rs, lcd_rw, lcd_en, lcd_dat_oe}, 0);

    // directed reads
    sq = '{8'h05};                         run_read("stat05", 1'b0, 1'b0, sq, 8'h00);
    sq = '{};                              run_read("data41", 1'b1, 1'b0, sq, 8'h41);
    sq = '{8'h80, 8'h80, 8'h80, 8'h12};    run_read("poll",   1'b1, 1'b1, sq, 8'h5A);
    sq = '{8'hA3, 8'h00};                  run_read("statwt", 1'b0, 1'b1, sq, 8'h00);

    // randomized reads
    for (int k = 0; k < 8; k++) begin
      logic r, w;
      int nb;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 3);
      sq = '{};
      for (int j = 0; j < nb; j++) sq.push_back(8'h80 | 8'($urandom_range(0, 127)));
      sq.push_back(8'($urandom_range(0, 127)));
      if (!r) sq[0] = 8'($urandom_range(0, 255));
      run_read($sformatf("rnd%0d", k), r, w, sq, 8'($urandom_range(0, 255)));
    end

    // back-to-back with rd_req held high
    data_byte = 8'h33;
    @(negedge clk); rd_rs = 1'b1; rd_wait = 1'b0; rd_req = 1'b1;
    acks = 0; bsy_low = 0; rw_at = 0; ack2 = 0;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (rd_ack) begin acks++; if (acks == 2) ack2 = n; end
      if (acks == 1 && !rd_busy) bsy_low++;
      if (acks == 1 && lcd_rw && rw_at == 0) rw_at = n;
      if (acks == 1 && rw_at != 0) rd_req = 1'b0;
    end
    rd_req = 1'b0;
    chk("b2b_acks", acks, 2);
    chk("b2b_bsylow", bsy_low, 1);
    chk("b2b_setup", rw_at, LAT + 2);
    chk("b2b_ack2", ack2, 2 * LAT + 1);

    // stuck busy flag
    stat_q = '{}; stat_dflt = 8'h80; data_byte = 8'h77;
`ifdef LCD_RD_TIMEOUT_EN
    issue(1'b1, 1'b1, 1000);
    chk("to_lat", lat, LAT + ACC * (PM - 1));
    chk("to_flag", rd_timeout, 1'b1);
    chk("to_data", rd_data, 8'h80);
    chk("to_rs1", n_rs1, 0);
    chk("to_rs0", n_rs0, PM);
`else
    issue(1'b1, 1'b1, LAT + ACC * 10 + 20);
    chk("stuck_noack", lat, LAT + ACC * 10 + 20);
    chk("stuck_polls", n_rs0 >= 10, 1'b1);
    chk("stuck_rs1", n_rs1, 0);
    chk("stuck_busy", rd_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif
    stat_dflt = 8'h00;

    // reset in the middle of EN high
    stat_q = '{8'h15};
    @(negedge clk); rd_rs = 1'b0; rd_wait = 1'b0; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    for (int n = 0; n < 14; n++) @(negedge clk);
    chk("mid_en_pre", lcd_en, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {rd_busy, rd_ack, rd_data, rd_bf, rd_ac, rd_timeout, lcd_rs, lcd_rw, lcd_en, lcd_dat_oe}, 0);
    @(negedge clk); rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_ack || lcd_en) acks++;
    end
    chk("mid_rst_noack", acks, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
